eth_rx_fcs_check: RTL and testbench

- Receive-side counterpart of the transmit crc32 FCS generator.
- Takes the 32-bit, byte-lane-valid RX frame stream from the PCS/decoder side, runs CRC-32 (IEEE 802.3) over the whole frame including the trailing 4-byte FCS, and checks the residue.
- Strips the FCS bytes and forwards the payload to the MAC RX client with a per-frame good/bad verdict on the last beat.

---
 rtl/eth_crc_pkg.sv | 44 ++++
 rtl/eth_rx_fcs_strip.sv | 63 ++++++
 rtl/eth_rx_fcs_check.sv | 109 ++++++++++
 tb/tb_eth_rx_fcs_check.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/eth_crc_pkg.sv
// Shared CRC-32 (IEEE 802.3) constants, beat type and per-beat step function,
// used by both the RX FCS checker and the TX FCS generator.
package eth_crc_pkg;

    localparam int unsigned DATA_BYTES      = 4;
    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] INITIAL_CRC     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE     = 32'hC704DD7B;
    localparam int unsigned MIN_FRAME_BYTES = 5;

    typedef enum logic {ST_IDLE, ST_ACTIVE} rx_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  valid;
        logic        last;
    } beat_t;

    // Reflected (LSB-first) update, lane 0 first, skipping invalid lanes.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                               input logic [31:0] data,
                                               input logic [3:0]  valid);
        logic [31:0] c;
        c = crc;
        for (int b = 0; b < 4; b++) begin
            if (valid[b]) begin
                for (int i = 0; i < 8; i++) begin
                    if (c[0] ^ data[8*b+i]) c = (c >> 1) ^ CRC32_POLY_REFL;
                    else                    c = c >> 1;
                end
            end
        end
        return c;
    endfunction

    // The residue constant is in MSB-first form; the register runs reflected.
    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

endpackage

// File: rtl/eth_rx_fcs_strip.sv
// One-beat hold register that delays the payload so the trailing FCS bytes,
// which may straddle two beats, can be dropped and the last beat trimmed.
module eth_rx_fcs_strip
    import eth_crc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic [3:0]  valid_i,
    input  logic        last_i,
    output logic        hold_full_o,
    output beat_t       out_beat_o
);

    logic [31:0] hold_q, hold_d;
    logic        full_q, full_d;
    beat_t       out_q, out_d;
    logic [31:0] lane_mask;

    always_comb begin
        for (int l = 0; l < 4; l++) lane_mask[8*l +: 8] = {8{valid_i[l]}};
    end

    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        out_d  = '0;
        if (|valid_i) begin
            if (last_i) begin
                // k valid lanes on the last beat leave k payload bytes in the held beat
                if (full_q) begin
                    out_d.data  = hold_q & lane_mask;
                    out_d.valid = valid_i;
                end
                out_d.last = 1'b1;
                full_d     = 1'b0;
            end else begin
                if (full_q) begin
                    out_d.data  = hold_q;
                    out_d.valid = 4'hF;
                end
                hold_d = data_i;
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            full_q <= 1'b0;
            out_q  <= '0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
            out_q  <= out_d;
        end
    end

    assign hold_full_o = full_q;
    assign out_beat_o  = out_q;

endmodule

// File: rtl/eth_rx_fcs_check.sv
// RX FCS checker: CRC-32 over frame + FCS, residue compare, FCS strip.
// Optional RX_FCS_STATS_EN adds saturating good/bad frame counters.
module eth_rx_fcs_check #(
    parameter int unsigned DATA_BYTES  = 4,
    parameter logic [31:0] INITIAL_CRC = eth_crc_pkg::INITIAL_CRC,
    parameter logic [31:0] CRC_RESIDUE = eth_crc_pkg::CRC_RESIDUE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_BYTES*8-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_valid,
    input  logic                    in_last,
    output logic [DATA_BYTES*8-1:0] out_data,
    output logic [DATA_BYTES-1:0]   out_valid,
    output logic                    out_last,
    output logic                    out_fcs_ok,
    output logic                    out_fcs_err,
    output logic                    out_runt
`ifdef RX_FCS_STATS_EN
    ,
    output logic [31:0]             stat_good_frames,
    output logic [31:0]             stat_bad_frames
`endif
);
    import eth_crc_pkg::*;

    rx_state_e   state_q, state_d;
    logic [31:0] crc_q, crc_d, crc_base, crc_next;
    logic        ok_q, ok_d, err_q, err_d, runt_q, runt_d;
    logic        beat_vld, match, hold_full;
    beat_t       strip_beat;

    assign beat_vld = |in_valid;
    assign crc_base = (state_q == ST_IDLE) ? INITIAL_CRC : crc_q;
    assign crc_next = crc32_step(crc_base, in_data, in_valid);
    assign match    = (bitrev32(crc_next) == CRC_RESIDUE);

    eth_rx_fcs_strip u_strip (
        .clk         (clk),
        .rst         (rst),
        .data_i      (in_data),
        .valid_i     (in_valid),
        .last_i      (in_last),
        .hold_full_o (hold_full),
        .out_beat_o  (strip_beat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            crc_q   <= INITIAL_CRC;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            runt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            runt_q  <= runt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        if (beat_vld) begin
            state_d = in_last ? ST_IDLE : ST_ACTIVE;
            crc_d   = in_last ? INITIAL_CRC : crc_next;
        end
    end

    // An empty hold register at the last beat means the frame had at most 4 bytes.
    always_comb begin
        ok_d   = 1'b0;
        err_d  = 1'b0;
        runt_d = 1'b0;
        if (beat_vld && in_last) begin
            runt_d = ~hold_full;
            ok_d   = hold_full & match;
            err_d  = ~(hold_full & match);
        end
    end

    assign out_data    = strip_beat.data;
    assign out_valid   = strip_beat.valid;
    assign out_last    = strip_beat.last;
    assign out_fcs_ok  = ok_q;
    assign out_fcs_err = err_q;
    assign out_runt    = runt_q;

`ifdef RX_FCS_STATS_EN
    logic [31:0] good_q, bad_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else if (out_last) begin
            if (out_fcs_ok  && good_q != 32'hFFFFFFFF) good_q <= good_q + 32'd1;
            if (out_fcs_err && bad_q  != 32'hFFFFFFFF) bad_q  <= bad_q + 32'd1;
        end
    end

    assign stat_good_frames = good_q;
    assign stat_bad_frames  = bad_q;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check; expected beats are hand-computed from
// the "123456789" / "12345678" CRC-32 check values.
module tb_eth_rx_fcs_check;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic        in_last;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic        out_last, out_fcs_ok, out_fcs_err, out_runt;
`ifdef RX_FCS_STATS_EN
    logic [31:0] stat_good_frames, stat_bad_frames;
`endif

    int total = 0;
    int bad   = 0;

    eth_rx_fcs_check dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_fcs_ok  (out_fcs_ok),
        .out_fcs_err (out_fcs_err),
        .out_runt    (out_runt)
`ifdef RX_FCS_STATS_EN
        ,
        .stat_good_frames (stat_good_frames),
        .stat_bad_frames  (stat_bad_frames)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat, clock it, then sample 1 ns after the edge.
    task automatic step(input logic [31:0] d, input logic [3:0] v, input logic l);
        in_data  = d;
        in_valid = v;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic [3:0] v,
                           input logic l, input logic ok, input logic err, input logic runt);
        logic [39:0] obs, exp;
        obs = {out_data, out_valid, out_last, out_fcs_ok, out_fcs_err, out_runt};
        exp = {d, v, l, ok, err, runt};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (data,valid,last,ok,err,runt)", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_data  = '0;
        in_valid = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset_state", 32'h0, 4'h0, 0, 0, 0, 0);
`ifdef RX_FCS_STATS_EN
        chk32("reset_good", stat_good_frames, 32'd0);
        chk32("reset_bad",  stat_bad_frames,  32'd0);
`endif
        rst = 1'b1;
        step(32'h0, 4'h0, 1'b0);
        chk_out("idle_after_reset", 32'h0, 4'h0, 0, 0, 0, 0);

        // 1: "123456789" + FCS, last beat k=1
        step(32'h34333231, 4'hF, 1'b0); chk_out("s1_b0", 32'h0, 4'h0, 0, 0, 0, 0);
        step(32'h38373635, 4'hF, 1'b0); chk_out("s1_b1", 32'h34333231, 4'hF, 0, 0, 0, 0);
        step(32'hF4392639, 4'hF, 1'b0); chk_out("s1_b2", 32'h38373635, 4'hF, 0, 0, 0, 0);
        step(32'h000000CB, 4'h1, 1'b1); chk_out("s1_last", 32'h00000039, 4'h1, 1, 1, 0, 0);
        step(32'h0, 4'h0, 1'b0);        chk_out("s1_gap", 32'h0, 4'h0, 0, 0, 0, 0);

        // 2: "12345678" + FCS, last beat k=4
        step(32'h34333231, 4'hF, 1'b0); chk_out("s2_b0", 32'h0, 4'h0, 0, 0, 0, 0);
        step(32'h38373635, 4'hF, 1'b0); chk_out("s2_b1", 32'h34333231, 4'hF, 0, 0, 0, 0);
        step(32'h9AE0DAAF, 4'hF, 1'b1); chk_out("s2_last", 32'h38373635, 4'hF, 1, 1, 0, 0);

        // 3: scenario 1 with corrupted FCS byte, back-to-back after scenario 2
        step(32'h34333231, 4'hF, 1'b0); chk_out("s3_b0", 32'h0, 4'h0, 0, 0, 0, 0);
        step(32'h38373635, 4'hF, 1'b0); chk_out("s3_b1", 32'h34333231, 4'hF, 0, 0, 0, 0);
        step(32'hF4392639, 4'hF, 1'b0); chk_out("s3_b2", 32'h38373635, 4'hF, 0, 0, 0, 0);
        step(32'h000000CA, 4'h1, 1'b1); chk_out("s3_last", 32'h00000039, 4'h1, 1, 0, 1, 0);

        // 4: single-beat runt
        step(32'hDEADBEEF, 4'hF, 1'b1); chk_out("s4_runt", 32'h0, 4'h0, 1, 0, 1, 1);
        step(32'h0, 4'h0, 1'b0);        chk_out("s4_gap", 32'h0, 4'h0, 0, 0, 0, 0);

        // 5: idle beats (garbage data, in_last set) mid-frame, then scenario 2 back-to-back
        step(32'h34333231, 4'hF, 1'b0); chk_out("s5_b0", 32'h0, 4'h0, 0, 0, 0, 0);
        step(32'h38373635, 4'hF, 1'b0); chk_out("s5_b1", 32'h34333231, 4'hF, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(32'hFFFFFFFF, 4'h0, 1'b1); chk_out("s5_idle", 32'h0, 4'h0, 0, 0, 0, 0);
        end
        step(32'hF4392639, 4'hF, 1'b0); chk_out("s5_b2", 32'h38373635, 4'hF, 0, 0, 0, 0);
        step(32'h000000CB, 4'h1, 1'b1); chk_out("s5_last", 32'h00000039, 4'h1, 1, 1, 0, 0);
        step(32'h34333231, 4'hF, 1'b0); chk_out("s5n_b0", 32'h0, 4'h0, 0, 0, 0, 0);
        step(32'h38373635, 4'hF, 1'b0); chk_out("s5n_b1", 32'h34333231, 4'hF, 0, 0, 0, 0);
        step(32'h9AE0DAAF, 4'hF, 1'b1); chk_out("s5n_last", 32'h38373635, 4'hF, 1, 1, 0, 0);
        step(32'h0, 4'h0, 1'b0);
`ifdef RX_FCS_STATS_EN
        chk32("stats_good_mid", stat_good_frames, 32'd4);
        chk32("stats_bad_mid",  stat_bad_frames,  32'd2);
`endif

        // 6: asynchronous reset mid-frame, then scenario 2
        step(32'h34333231, 4'hF, 1'b0); chk_out("s6_b0", 32'h0, 4'h0, 0, 0, 0, 0);
        step(32'h38373635, 4'hF, 1'b0); chk_out("s6_b1", 32'h34333231, 4'hF, 0, 0, 0, 0);
        in_data  = 32'h0;
        in_valid = 4'h0;
        in_last  = 1'b0;
        rst = 1'b0;
        #1;
        chk_out("s6_async_rst", 32'h0, 4'h0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_out("s6_in_rst", 32'h0, 4'h0, 0, 0, 0, 0);
        rst = 1'b1;
        step(32'h34333231, 4'hF, 1'b0); chk_out("s6_r_b0", 32'h0, 4'h0, 0, 0, 0, 0);
        step(32'h38373635, 4'hF, 1'b0); chk_out("s6_r_b1", 32'h34333231, 4'hF, 0, 0, 0, 0);
        step(32'h9AE0DAAF, 4'hF, 1'b1); chk_out("s6_r_last", 32'h38373635, 4'hF, 1, 1, 0, 0);
        step(32'h0, 4'h0, 1'b0);        chk_out("s6_end", 32'h0, 4'h0, 0, 0, 0, 0);
`ifdef RX_FCS_STATS_EN
        chk32("stats_good", stat_good_frames, 32'd1);
        chk32("stats_bad",  stat_bad_frames,  32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
